// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request and fetch-address bundle between the control/ALU
// side (master) and the program-counter sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             take_branch;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [25:0]      jump_address;
    logic             jr;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_4;
    logic             redirect;
    logic             misalign_fault;

    modport master (
        output stall, take_branch, branch_offset, jump, jump_address, jr, jr_target,
        input  pc, pc_plus_4, redirect, misalign_fault
    );

    modport slave (
        input  stall, take_branch, branch_offset, jump, jump_address, jr, jr_target,
        output pc, pc_plus_4, redirect, misalign_fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with branch/jump/jr selection,
// stall, reset vector and sticky target-misalignment fault.
// Optional branch delay slot enabled by defining DELAY_SLOT_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus_4;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] sel_target;
    logic             req;
    logic             target_bad;
    logic             redirect_q, redirect_d;
    logic             fault_q, fault_d;

`ifdef DELAY_SLOT_EN
    typedef enum logic {SEQ, SLOT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
`endif

    assign pc_plus_4     = pc_q + WIDTH'(4);
    assign branch_target = pc_plus_4 + (bus.branch_offset << 2);
    assign jump_target   = {pc_plus_4[WIDTH-1:28], bus.jump_address, 2'b00};

    // Priority select of the redirect target: jr > jump > branch
    always_comb begin
        req        = 1'b1;
        sel_target = branch_target;
        if (bus.jr)               sel_target = bus.jr_target;
        else if (bus.jump)        sel_target = jump_target;
        else if (bus.take_branch) sel_target = branch_target;
        else                      req = 1'b0;
        target_bad = req && (sel_target[1:0] != 2'b00);
    end

    // Next-state: stall freezes everything; misaligned targets fall through sequentially
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        fault_d    = fault_q;
`ifdef DELAY_SLOT_EN
        state_d    = state_q;
        pending_d  = pending_q;
        if (!bus.stall) begin
            if (state_q == SLOT) begin
                pc_d       = pending_q;
                redirect_d = 1'b1;
                state_d    = SEQ;
            end else if (target_bad) begin
                pc_d    = pc_plus_4;
                fault_d = 1'b1;
            end else if (req) begin
                pc_d      = pc_plus_4;
                pending_d = sel_target;
                state_d   = SLOT;
            end else begin
                pc_d = pc_plus_4;
            end
        end
`else
        if (!bus.stall) begin
            if (req && !target_bad) begin
                pc_d       = sel_target;
                redirect_d = 1'b1;
            end else begin
                pc_d = pc_plus_4;
                if (target_bad) fault_d = 1'b1;
            end
        end
`endif
    end

    // State registers with asynchronous reset to the reset vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            redirect_q <= 1'b0;
            fault_q    <= 1'b0;
`ifdef DELAY_SLOT_EN
            state_q    <= SEQ;
            pending_q  <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            fault_q    <= fault_d;
`ifdef DELAY_SLOT_EN
            state_q    <= state_d;
            pending_q  <= pending_d;
`endif
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus_4      = pc_plus_4;
    assign bus.redirect       = redirect_q;
    assign bus.misalign_fault = fault_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit for the MIPS core. It replaces the PC register and the branch/jump/jr mux chain with one registered sequencer. The unit adds stall, reset vector, target-misalignment fault and an optional branch delay slot. It sits between the control/ALU outputs and the instruction-memory address.

Parameters:
WIDTH, 32, PC/address width in bits; legal range 32..64.
RESET_VECTOR, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC and all state this cycle
take_branch  input  1  conditional branch resolved taken (Branch AND zero)
branch_offset  input  WIDTH  sign-extended word offset (immediate, not yet shifted)
jump  input  1  J/JAL request
jump_address  input  26  instruction index field
jr  input  1  jump-register request
jr_target  input  WIDTH  register value for jr
pc  output  WIDTH  current fetch address
pc_plus_4  output  WIDTH  pc + 4, combinational from pc
redirect  output  1  registered 1-cycle pulse: pc was loaded with a non-sequential target on the last edge
misalign_fault  output  1  sticky: a selected target had bits [1:0] != 0

Behaviour:
- Reset (async, any time, including mid-delay-slot): pc = RESET_VECTOR, redirect = 0, misalign_fault = 0, state = SEQ, pending target cleared.
- Arithmetic: all sums are modulo 2^WIDTH; the carry out is dropped.
  - pc_plus_4 = pc + 4.
  - Branch target = pc_plus_4 + (branch_offset << 2).
  - Jump target = {pc_plus_4[WIDTH-1:28], jump_address, 2'b00}.
  - jr target = jr_target.
- Priority when several requests are asserted together: jr > jump > take_branch > sequential.
- stall = 1: pc, state, pending target and misalign_fault hold; redirect drives 0 that cycle; all request inputs are ignored.
- Misaligned selected target (jr only in practice, target[1:0] != 0):
  - the redirect is not taken;
  - pc <= pc_plus_4;
  - misalign_fault <= 1 and stays at 1 until reset.
- Latency: a request at edge N appears on pc after edge N (without delay slot) or after edge N+1 (with delay slot; see below).
- Wrap: pc = all-ones minus 3 advancing sequentially wraps to 0; this is not a fault.
- State machine: without the optional feature there is a single state SEQ; every non-stalled edge loads the selected target.

Optional Feature:
Macro DELAY_SLOT_EN.
- Defined: two states, SEQ and SLOT.
  - In SEQ, a valid redirect request sets pc <= pc_plus_4, latches the target into pending_target and moves to SLOT; redirect = 0.
  - In SLOT, the next non-stalled edge sets pc <= pending_target, redirect <= 1 and returns to SEQ. All requests arriving in SLOT are ignored (a branch inside a delay slot is architecturally undefined and is dropped).
  - Stall in SLOT holds SLOT.
  - Reset in SLOT returns to SEQ and discards pending_target.
  - A misalignment check happens at capture time in SEQ; a faulting target never enters SLOT.
- Undefined: a redirect takes effect on the same edge it is requested; the SLOT state and pending_target register do not exist.

Test Plan:
1. Reset with RESET_VECTOR=0x00400000, release, 3 idle cycles -> pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; redirect = 0 throughout.
2. pc=0x00400010, take_branch=1, branch_offset=0xFFFFFFFC -> next pc = 0x00400004, redirect pulses 1 for exactly one cycle. With DELAY_SLOT_EN: pc = 0x00400014, then 0x00400004.
3. pc=0x10000000, jr=1, jr_target=0x00400100, jump=1, jump_address=0x0000040, take_branch=1 simultaneously -> pc = 0x00400100 (jr wins).
4. pc=0x00400020, jr=1, jr_target=0x00400102 -> pc = 0x00400024, misalign_fault = 1 and stays 1 over 10 further cycles until reset.
5. stall=1 for 3 cycles while jump=1, jump_address=0x0100000 -> pc is unchanged and redirect = 0. After stall drops with jump held -> pc = 0x00400000.
6. DELAY_SLOT_EN: assert jump, then assert reset asynchronously mid-cycle while in SLOT -> pc is immediately RESET_VECTOR, state = SEQ, and no redirect to the pending target ever occurs.
